uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
- 16x-oversampling UART receiver: 8N1 serial input to parallel bytes, the receive counterpart of the team's uart_tx.
- Samples rxd on the system clock through an internal oversample-tick divider.
- Majority-votes each bit, checks the stop bit, and holds each byte in a one-deep output register with a valid/ready handshake.
- Sits beside uart_tx in uart_top; consumes its serial line in loopback.

Parameters:
- DATA_BITS, 8, data bits per frame, LSB first.
- OVERSAMPLE, 16, ticks per bit period.
- DIV, 27, clk cycles per oversample tick; must be >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- rxd  input  1  serial line, idle high, asynchronous to clk.
- dout  output  DATA_BITS  received byte, stable while dout_valid is high.
- dout_valid  output  1  byte available; held until accepted.
- dout_ready  input  1  consumer accepts the byte when dout_valid && dout_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: a byte completed while the holding register was full; the new byte is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rstn low):
  - dout=0, dout_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops=1, state=IDLE, all counters=0.
  - Takes effect immediately, including mid-frame.
- Input synchronization:
  - 2-flop synchronizer on rxd, plus one history flop.
  - Start edge = synced 0 with history 1.
- Tick generation:
  - Counter runs 0..DIV-1; tick when the count is DIV-1.
  - Forced to 0 on the start edge, so ticks are phase-aligned to the frame.
- Sampling:
  - Sample counter s runs 0..OVERSAMPLE-1 per bit.
  - Samples are taken at ticks s=7, 8 and 9; the bit value is the 2-of-3 majority.
- FSM states:
  - IDLE: on start edge -> START; clear s and the bit index.
  - START: at s=9, majority 0 -> DATA; majority 1 (false start/glitch) -> IDLE. At s=OVERSAMPLE-1 (on the tick) -> advance to the next bit, s=0.
  - DATA: each bit's majority is shifted into a shift register, LSB first. After bit DATA_BITS-1 completes its OVERSAMPLE ticks -> STOP.
  - STOP, at s=9:
    - majority 1 -> deliver the byte, then IDLE. Returning half a bit early lets a back-to-back start edge be caught.
    - majority 0 -> frame_err pulse, byte discarded -> BREAK.
  - BREAK: wait for synced rxd=1, then IDLE. No start detection while in BREAK.
- Delivery (the clk cycle after the s=9 stop tick):
  - dout_valid=0 -> dout loaded, dout_valid=1.
  - dout_valid=1 and dout_ready=1 in the same cycle -> new byte loaded, dout_valid stays 1, no overrun.
  - dout_valid=1 and dout_ready=0 -> dout unchanged, overrun pulse, new byte dropped.
- Handshake:
  - dout_valid && dout_ready at a clk edge clears dout_valid (absent a simultaneous delivery).
  - dout holds its last value after acceptance.
- Frame timing:
  - One frame spans (DATA_BITS+2)*OVERSAMPLE*DIV clk.
  - Delivery occurs about 9.5*OVERSAMPLE*DIV clk after the start edge, plus 2-3 clk of synchronizer latency.
- Counter widths:
  - Tick counter is clog2(DIV) bits; sample counter is clog2(OVERSAMPLE); bit index is clog2(DATA_BITS+1).
  - No wrap beyond the stated terminal counts.

Decomposition:
- Package uart_pkg holds:
  - State encoding: IDLE, START, DATA, STOP, BREAK.
  - Sample positions: MID_LO=7, MID=8, MID_HI=9.
  - Frame constants shared with uart_tx: START_BIT=0, STOP_BIT=1.
- One sub-module, uart_os_tick: DIV divider with a synchronous restart input and a tick output.
- Synchronizer, FSM, shift register and holding register live in uart_rx_os.

Test Plan (DIV=4, OVERSAMPLE=16, i.e. 64 clk per bit):
- Frame 0xA5, stop=1, dout_ready tied 1 -> dout=0xA5; dout_valid high exactly 1 cycle; frame_err=0; overrun=0; busy falls at the stop mid-bit.
- rxd low for 8 clk, then high -> START rejects at s=9 -> IDLE; no dout_valid; busy high for about 40 clk only.
- Frame 0x3C with stop=0, then line held low 200 clk, then high -> one frame_err pulse; dout_valid stays 0; no start accepted until rxd returns high; a following 0x81 frame is received correctly.
- Frames 0x11 then 0x22 back-to-back, dout_ready=0 -> dout=0x11 and valid held; overrun pulses once at 0x22 delivery; then dout_ready=1 for one cycle -> dout_valid drops, dout stays 0x11.
- rstn pulsed low during data bit 3 of 0x5A -> all outputs 0 asynchronously, busy=0; next full 0x5A frame -> dout=0x5A.
- Frame 0xFF with rxd forced low only at the tick s=8 of each data bit -> majority vote yields dout=0xFF, frame_err=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample positions
// used for the majority vote, and frame-level bit values that uart_tx also
// uses.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Oversample ticks at which a bit is sampled for the 2-of-3 vote.
    localparam int MID_LO = 7;
    localparam int MID    = 8;
    localparam int MID_HI = 9;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick divider: pulses tick for one clk every DIV clk.
// restart zeroes the count so tick phase lines up with a detected start edge.
// Ports:
//   clk     system clock
//   rstn    asynchronous active-low reset
//   restart synchronous counter clear
//   tick    one-cycle pulse when the count reaches DIV-1
module uart_os_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampling 8N1 UART receiver with a one-deep valid/ready output.
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge on the synced line
//   START | checking the start bit at its mid-samples, then its remainder
//   DATA  | sampling data bits LSB first into the shift register
//   STOP  | checking the stop bit at its mid-samples
//   BREAK | stop bit was low; wait for the line to return high
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   rxd        serial input, idle high, asynchronous to clk
//   dout       received byte, stable while dout_valid is high
//   dout_valid byte available, held until accepted
//   dout_ready consumer accepts when dout_valid && dout_ready
//   frame_err  one-cycle pulse when the stop bit votes low
//   overrun    one-cycle pulse when a byte is dropped because dout was full
//   busy       high whenever the receiver is not IDLE
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = 27
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    rx_state_t state, state_nxt;

    logic                 rx_meta, rx_sync, rx_hist;
    logic                 tick;
    logic [SW-1:0]        s;
    logic [BW-1:0]        bit_idx;
    logic                 samp_lo, samp_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 deliver_pend;

    logic start_edge, restart, at_lo, at_mid, at_hi, s_last, maj;
    logic shift_en, fe_set, deliver_set;

    assign start_edge = (rx_sync == START_BIT) && (rx_hist == STOP_BIT);
    assign restart    = (state == IDLE) && start_edge;
    assign at_lo      = tick && (s == SW'(MID_LO));
    assign at_mid     = tick && (s == SW'(MID));
    assign at_hi      = tick && (s == SW'(MID_HI));
    assign s_last     = (s == SW'(OVERSAMPLE - 1));
    // Third vote comes straight from the line on the s=MID_HI tick.
    assign maj        = maj3(samp_lo, samp_mid, rx_sync);
    assign busy       = (state != IDLE);

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_hist <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;
            rx_hist <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DATA is entered mid start bit; bit_idx stays 0 through the rest of the
    // start bit, so the first DATA sample at s=MID_HI belongs to data bit 0.
    always_comb begin
        state_nxt   = state;
        shift_en    = 1'b0;
        fe_set      = 1'b0;
        deliver_set = 1'b0;
        case (state)
            IDLE: begin
                if (start_edge) state_nxt = START;
            end
            START: begin
                if (at_hi) state_nxt = (maj == START_BIT) ? DATA : IDLE;
            end
            DATA: begin
                if (at_hi && (bit_idx != BW'(DATA_BITS))) shift_en = 1'b1;
                if (tick && s_last && (bit_idx == BW'(DATA_BITS))) state_nxt = STOP;
            end
            STOP: begin
                if (at_hi) begin
                    if (maj == STOP_BIT) begin
                        deliver_set = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        fe_set    = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync == STOP_BIT) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s        <= '0;
            bit_idx  <= '0;
            samp_lo  <= 1'b1;
            samp_mid <= 1'b1;
            shreg    <= '0;
        end else begin
            if (restart) begin
                s       <= '0;
                bit_idx <= '0;
            end else begin
                if (tick && (state != IDLE) && (state != BREAK)) begin
                    s <= s_last ? '0 : s + SW'(1);
                end
                if (shift_en) begin
                    bit_idx <= bit_idx + BW'(1);
                end
            end
            if (at_lo)    samp_lo  <= rx_sync;
            if (at_mid)   samp_mid <= rx_sync;
            if (shift_en) shreg    <= {maj, shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            deliver_pend <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
            dout         <= '0;
            dout_valid   <= 1'b0;
        end else begin
            deliver_pend <= deliver_set;
            frame_err    <= fe_set;
            overrun      <= 1'b0;
            if (deliver_pend) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= shreg;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=4, OVERSAMPLE=16 (64 clk per bit).
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_os #(.DATA_BITS(8), .OVERSAMPLE(16), .DIV(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Event monitor: counts sampled on the falling edge, accepted bytes logged.
    int         valid_cycles = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         busy_cycles = 0;
    int         acc_cnt = 0;
    logic [7:0] got_mem [0:63];

    always @(negedge clk) begin
        if (dout_valid) valid_cycles <= valid_cycles + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
        if (overrun)    ov_cnt <= ov_cnt + 1;
        if (busy)       busy_cycles <= busy_cycles + 1;
        if (dout_valid && dout_ready) begin
            got_mem[acc_cnt] <= dout;
            acc_cnt <= acc_cnt + 1;
        end
    end

    int         total = 0;
    int         bad = 0;
    int         consumed = 0;
    logic [7:0] exp_q [$];
    int         b_valid, b_fe, b_ov, b_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rxd = v;
        end
    endtask

    // glitch pulls the line low for a few clk around the s=8 sample of each data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic glitch);
        logic v;
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < 64; c++) begin
                @(posedge clk); #1;
                if (k == 0)      v = 1'b0;
                else if (k == 9) v = stop_v;
                else             v = b[k-1];
                if (glitch && k >= 1 && k <= 8 && c >= 34 && c <= 38) v = 1'b0;
                rxd = v;
            end
        end
    endtask

    task automatic check_rx(input string tag);
        logic [7:0] e;
        for (int i = 0; i < 200 && acc_cnt <= consumed; i++) @(negedge clk);
        chk({tag, "_arrived"}, 32'(acc_cnt > consumed), 32'd1);
        if (acc_cnt > consumed && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, 32'(got_mem[consumed]), 32'(e));
            consumed++;
        end
    endtask

    task automatic snap();
        b_valid = valid_cycles;
        b_fe    = fe_cnt;
        b_ov    = ov_cnt;
        b_busy  = busy_cycles;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_fe", 32'(frame_err), 32'd0);
        chk("rst_ov", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        drive(1'b1, 20);

        // Clean frame, consumer always ready.
        snap();
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        drive(1'b1, 10);
        check_rx("a5_byte");
        chk("a5_valid_cycles", 32'(valid_cycles - b_valid), 32'd1);
        chk("a5_fe", 32'(fe_cnt - b_fe), 32'd0);
        chk("a5_ov", 32'(ov_cnt - b_ov), 32'd0);
        chk("a5_busy_len", 32'((busy_cycles - b_busy) >= 612 && (busy_cycles - b_busy) <= 620), 32'd1);
        chk("a5_busy_end", 32'(busy), 32'd0);

        // Short low glitch must be rejected during the start bit.
        snap();
        drive(1'b0, 8);
        drive(1'b1, 100);
        chk("glitch_valid", 32'(valid_cycles - b_valid), 32'd0);
        chk("glitch_busy_len", 32'((busy_cycles - b_busy) >= 38 && (busy_cycles - b_busy) <= 42), 32'd1);
        chk("glitch_busy_end", 32'(busy), 32'd0);

        // Framing error followed by a held break, then a good frame.
        snap();
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 200);
        chk("brk_fe", 32'(fe_cnt - b_fe), 32'd1);
        chk("brk_valid", 32'(valid_cycles - b_valid), 32'd0);
        chk("brk_busy_held", 32'(busy), 32'd1);
        drive(1'b1, 20);
        chk("brk_busy_end", 32'(busy), 32'd0);
        drive(1'b1, 50);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, 10);
        check_rx("b81_byte");

        // Back-to-back frames with the consumer stalled: second byte dropped.
        dout_ready = 1'b0;
        snap();
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        drive(1'b1, 10);
        chk("ovr_dout", 32'(dout), 32'h11);
        chk("ovr_valid", 32'(dout_valid), 32'd1);
        chk("ovr_pulses", 32'(ov_cnt - b_ov), 32'd1);
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        chk("ovr_valid_drop", 32'(dout_valid), 32'd0);
        chk("ovr_dout_hold", 32'(dout), 32'h11);
        check_rx("ovr_byte");
        dout_ready = 1'b1;
        drive(1'b1, 10);

        // Reset in the middle of data bit 3 of 0x5A.
        drive(1'b0, 64);
        drive(1'b0, 64);
        drive(1'b1, 64);
        drive(1'b0, 64);
        drive(1'b1, 32);
        @(negedge clk);
        rstn = 1'b0;
        #2;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_valid", 32'(dout_valid), 32'd0);
        chk("arst_fe", 32'(frame_err), 32'd0);
        chk("arst_ov", 32'(overrun), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        drive(1'b1, 4);
        rstn = 1'b1;
        drive(1'b1, 100);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        drive(1'b1, 10);
        check_rx("r5a_byte");

        // Single-sample dropouts on every data bit are outvoted.
        snap();
        exp_q.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 1'b1);
        drive(1'b1, 10);
        check_rx("ff_byte");
        chk("ff_fe", 32'(fe_cnt - b_fe), 32'd0);

        drive(1'b1, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
